// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester ids and
// address-region bases of the NES memory map.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } arb_state_t;

   localparam logic [1:0] REQ_LDR = 2'd0;
   localparam logic [1:0] REQ_PPU = 2'd1;
   localparam logic [1:0] REQ_CPU = 2'd2;

   // Top nibble of a 22-bit address selects the region.
   localparam logic [3:0] PRGROM = 4'b0000;
   localparam logic [3:0] CHRROM = 4'b1000;
   localparam logic [3:0] VRAM   = 4'b1100;
   localparam logic [3:0] RAM    = 4'b1110;
   localparam logic [3:0] PRGRAM = 4'b1111;

endpackage

// File: rtl/mem_req_slot.sv
// One requester's holding register: pending flag, latched addr/data/we and
// a sticky overrun flag for requests that arrive while already pending.
module mem_req_slot #(
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        din,
   input  logic              clr,
   output logic              pend,
   output logic              pend_we,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [7:0]        pend_din,
   output logic              overrun
);

   logic accept;

   // A request coinciding with completion of the previous one is taken as new.
   assign accept = req && (!pend || clr);

   always_ff @(posedge clk) begin
      if (reset) begin
         pend    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (accept) begin
            pend <= 1'b1;
         end else if (clr) begin
            pend <= 1'b0;
         end
         if (req && pend && !clr) begin
            overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         pend_addr <= addr;
         pend_din  <= din;
         pend_we   <= we;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates loader, PPU and CPU accesses onto the single MemoryController
// port, one strobe per transaction, returning data and a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 3,
   parameter int ADDR_W       = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_din,
   output logic              ldr_ack,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic              ppu_ack,
   output logic [7:0]        ppu_dout,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_dout,
   output logic              overrun,
   output logic              mc_read_a,
   output logic              mc_read_b,
   output logic              mc_write,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [7:0]        mc_din,
   input  logic              mc_busy,
   input  logic [7:0]        mc_dout_a,
   input  logic [7:0]        mc_dout_b
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t        state, state_d;
   logic [1:0]        win, win_q;
   logic              grant, done, sel_we, cpu_starved;
   logic [CNT_W-1:0]  starve_cnt;
   logic [2:0]        pend, pend_we, clr, ovr;
   logic [ADDR_W-1:0] pend_addr [3];
   logic [7:0]        pend_din  [3];
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_din;

   mem_req_slot #(.ADDR_W(ADDR_W)) u_slot_ldr (
      .clk(clk), .reset(reset), .req(ldr_req), .we(1'b1), .addr(ldr_addr), .din(ldr_din),
      .clr(clr[REQ_LDR]), .pend(pend[REQ_LDR]), .pend_we(pend_we[REQ_LDR]),
      .pend_addr(pend_addr[REQ_LDR]), .pend_din(pend_din[REQ_LDR]), .overrun(ovr[REQ_LDR])
   );

   mem_req_slot #(.ADDR_W(ADDR_W)) u_slot_ppu (
      .clk(clk), .reset(reset), .req(ppu_req), .we(1'b0), .addr(ppu_addr), .din(8'h00),
      .clr(clr[REQ_PPU]), .pend(pend[REQ_PPU]), .pend_we(pend_we[REQ_PPU]),
      .pend_addr(pend_addr[REQ_PPU]), .pend_din(pend_din[REQ_PPU]), .overrun(ovr[REQ_PPU])
   );

   mem_req_slot #(.ADDR_W(ADDR_W)) u_slot_cpu (
      .clk(clk), .reset(reset), .req(cpu_req), .we(cpu_we), .addr(cpu_addr), .din(cpu_din),
      .clr(clr[REQ_CPU]), .pend(pend[REQ_CPU]), .pend_we(pend_we[REQ_CPU]),
      .pend_addr(pend_addr[REQ_CPU]), .pend_din(pend_din[REQ_CPU]), .overrun(ovr[REQ_CPU])
   );

   assign overrun     = |ovr;
   assign done        = (state == WAIT_LO) && !mc_busy;
   assign cpu_starved = pend[REQ_CPU] && (starve_cnt == CNT_MAX);

   always_comb begin
      grant = 1'b0;
      win   = REQ_LDR;
      if (state == IDLE && !mc_busy) begin
         if (pend[REQ_LDR]) begin
            grant = 1'b1;
            win   = REQ_LDR;
         end else if (pend[REQ_PPU] && !cpu_starved) begin
            grant = 1'b1;
            win   = REQ_PPU;
         end else if (pend[REQ_CPU]) begin
            grant = 1'b1;
            win   = REQ_CPU;
         end
      end
   end

   always_comb begin
      sel_addr = pend_addr[REQ_LDR];
      sel_din  = pend_din[REQ_LDR];
      sel_we   = pend_we[REQ_LDR];
      case (win)
         REQ_PPU: begin
            sel_addr = pend_addr[REQ_PPU];
            sel_din  = pend_din[REQ_PPU];
            sel_we   = pend_we[REQ_PPU];
         end
         REQ_CPU: begin
            sel_addr = pend_addr[REQ_CPU];
            sel_din  = pend_din[REQ_CPU];
            sel_we   = pend_we[REQ_CPU];
         end
         default: ;
      endcase
   end

   always_comb begin
      clr = 3'b000;
      if (done) begin
         case (win_q)
            REQ_LDR: clr[REQ_LDR] = 1'b1;
            REQ_PPU: clr[REQ_PPU] = 1'b1;
            REQ_CPU: clr[REQ_CPU] = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   state_d = WAIT_HI;
         WAIT_HI: if (mc_busy) state_d = WAIT_LO;
         WAIT_LO: if (!mc_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Strobes and acks are single-cycle: cleared every cycle unless re-armed.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_q      <= REQ_LDR;
         starve_cnt <= '0;
         mc_read_a  <= 1'b0;
         mc_read_b  <= 1'b0;
         mc_write   <= 1'b0;
         mc_addr    <= '0;
         mc_din     <= '0;
         ldr_ack    <= 1'b0;
         ppu_ack    <= 1'b0;
         cpu_ack    <= 1'b0;
         ppu_dout   <= '0;
         cpu_dout   <= '0;
      end else begin
         mc_read_a <= 1'b0;
         mc_read_b <= 1'b0;
         mc_write  <= 1'b0;
         ldr_ack   <= 1'b0;
         ppu_ack   <= 1'b0;
         cpu_ack   <= 1'b0;
         if (grant) begin
            win_q   <= win;
            mc_addr <= sel_addr;
            mc_din  <= sel_din;
            case (win)
               REQ_LDR: mc_write  <= 1'b1;
               REQ_PPU: mc_read_b <= 1'b1;
               default: begin
                  if (sel_we) mc_write <= 1'b1;
                  else        mc_read_a <= 1'b1;
               end
            endcase
         end
         if (done) begin
            case (win_q)
               REQ_LDR: ldr_ack <= 1'b1;
               REQ_PPU: begin
                  ppu_ack  <= 1'b1;
                  ppu_dout <= mc_dout_b;
               end
               default: begin
                  cpu_ack <= 1'b1;
                  if (!pend_we[REQ_CPU]) cpu_dout <= mc_dout_a;
               end
            endcase
         end
         if (!pend[REQ_CPU] || (grant && win == REQ_CPU)) begin
            starve_cnt <= '0;
         end else if (grant && win == REQ_PPU && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a three-cycle-busy MemoryController model.
module tb_mem_arbiter;

   localparam int ADDR_W = 22;

   logic              clk = 1'b0;
   logic              reset;
   logic              ldr_req, ppu_req, cpu_req, cpu_we;
   logic [ADDR_W-1:0] ldr_addr, ppu_addr, cpu_addr;
   logic [7:0]        ldr_din, cpu_din;
   logic              ldr_ack, ppu_ack, cpu_ack, overrun;
   logic [7:0]        ppu_dout, cpu_dout;
   logic              mc_read_a, mc_read_b, mc_write, mc_busy;
   logic [ADDR_W-1:0] mc_addr;
   logic [7:0]        mc_din;
   logic [7:0]        mc_dout_a = 8'h00;
   logic [7:0]        mc_dout_b = 8'h00;
   logic [1:0]        busy_cnt = 2'd0;

   int checks = 0;
   int errors = 0;
   int ldr_acks = 0, ppu_acks = 0, cpu_acks = 0;
   int a0, p0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(3), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
      .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .overrun(overrun),
      .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
      .mc_addr(mc_addr), .mc_din(mc_din), .mc_busy(mc_busy),
      .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b)
   );

   function automatic logic [7:0] rd_model(input logic [ADDR_W-1:0] a);
      if (a[7:0] == 8'h10) return 8'h5A;
      return a[7:0] ^ 8'h3C;
   endfunction

   // Controller model: busy for the three cycles after any strobe, ignores reset.
   always @(posedge clk) begin
      if (mc_read_a || mc_read_b || mc_write) busy_cnt <= 2'd3;
      else if (busy_cnt != 2'd0)             busy_cnt <= busy_cnt - 2'd1;
      if (mc_read_a) mc_dout_a <= rd_model(mc_addr);
      if (mc_read_b) mc_dout_b <= rd_model(mc_addr);
   end
   assign mc_busy = (busy_cnt != 2'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (ldr_ack) ldr_acks++;
      if (ppu_ack) ppu_acks++;
      if (cpu_ack) cpu_acks++;
      chk("strobe_onehot", 32'($countones({mc_read_a, mc_read_b, mc_write}) <= 1), 32'd1);
      chk("strobe_while_busy", 32'((mc_read_a || mc_read_b || mc_write) && mc_busy), 32'd0);
   end

   initial begin
      reset = 1'b1;
      ldr_req = 1'b0; ppu_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      ldr_addr = '0; ppu_addr = '0; cpu_addr = '0; ldr_din = '0; cpu_din = '0;
      step(3);
      chk("rst_acks", {29'd0, ldr_ack, ppu_ack, cpu_ack}, 32'd0);
      chk("rst_strobes", {29'd0, mc_read_a, mc_read_b, mc_write}, 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_mc_addr", 32'(mc_addr), 32'd0);
      chk("rst_mc_din", 32'(mc_din), 32'd0);
      chk("rst_douts", {16'd0, cpu_dout, ppu_dout}, 32'd0);
      reset = 1'b0;
      step(1);

      // single CPU read, uncontended
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h380010;
      step(1); cpu_req = 1'b0;
      chk("t1_no_early_strobe", 32'(mc_read_a), 32'd0);
      step(1);
      chk("t1_read_a", 32'(mc_read_a), 32'd1);
      chk("t1_mc_addr", 32'(mc_addr), 32'h380010);
      chk("t1_other_strobes", {30'd0, mc_read_b, mc_write}, 32'd0);
      step(1);
      chk("t1_strobe_one_cycle", 32'(mc_read_a), 32'd0);
      step(3);
      chk("t1_no_early_ack", 32'(cpu_ack), 32'd0);
      step(1);
      chk("t1_cpu_ack", 32'(cpu_ack), 32'd1);
      chk("t1_cpu_dout", 32'(cpu_dout), 32'h5A);
      step(1);
      chk("t1_ack_pulse", 32'(cpu_ack), 32'd0);
      chk("t1_dout_hold", 32'(cpu_dout), 32'h5A);

      // PPU and CPU together: PPU first, CPU strobe one cycle after ppu_ack
      a0 = cpu_acks; p0 = ppu_acks;
      ppu_req = 1'b1; ppu_addr = 22'h200020;
      cpu_req = 1'b1; cpu_addr = 22'h380010;
      step(1); ppu_req = 1'b0; cpu_req = 1'b0;
      step(1);
      chk("t2_read_b", 32'(mc_read_b), 32'd1);
      chk("t2_no_read_a", 32'(mc_read_a), 32'd0);
      chk("t2_mc_addr_ppu", 32'(mc_addr), 32'h200020);
      step(5);
      chk("t2_ppu_ack", 32'(ppu_ack), 32'd1);
      chk("t2_ppu_dout", 32'(ppu_dout), 32'h1C);
      chk("t2_cpu_not_yet", 32'(cpu_ack), 32'd0);
      step(1);
      chk("t2_read_a_follow", 32'(mc_read_a), 32'd1);
      chk("t2_mc_addr_cpu", 32'(mc_addr), 32'h380010);
      step(5);
      chk("t2_cpu_ack", 32'(cpu_ack), 32'd1);
      step(2);
      chk("t2_cpu_ack_once", 32'(cpu_acks - a0), 32'd1);
      chk("t2_ppu_ack_once", 32'(ppu_acks - p0), 32'd1);

      // PPU keeps re-requesting as each access completes while CPU waits
      ppu_req = 1'b1; ppu_addr = 22'h200020;
      cpu_req = 1'b1; cpu_addr = 22'h380010;
      step(1); ppu_req = 1'b0; cpu_req = 1'b0;
      step(1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t3_ppu_win%0d", k), 32'(mc_read_b), 32'd1);
         chk($sformatf("t3_cpu_wait%0d", k), 32'(mc_read_a), 32'd0);
         step(4);
         ppu_req = 1'b1;
         step(1);
         ppu_req = 1'b0;
         chk($sformatf("t3_ppu_ack%0d", k), 32'(ppu_ack), 32'd1);
         step(1);
      end
      chk("t3_cpu_forced", 32'(mc_read_a), 32'd1);
      chk("t3_ppu_held_off", 32'(mc_read_b), 32'd0);
      step(5);
      chk("t3_cpu_ack", 32'(cpu_ack), 32'd1);
      step(1);
      chk("t3_ppu_after_cpu", 32'(mc_read_b), 32'd1);
      step(5);
      chk("t3_last_ppu_ack", 32'(ppu_ack), 32'd1);
      step(2);
      chk("t3_no_overrun", 32'(overrun), 32'd0);

      // loader beats pending PPU and CPU
      ldr_req = 1'b1; ldr_addr = 22'h020000; ldr_din = 8'hA9;
      ppu_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
      step(1); ldr_req = 1'b0; ppu_req = 1'b0; cpu_req = 1'b0;
      step(1);
      chk("t4_write", 32'(mc_write), 32'd1);
      chk("t4_no_reads", {30'd0, mc_read_a, mc_read_b}, 32'd0);
      chk("t4_mc_din", 32'(mc_din), 32'hA9);
      chk("t4_mc_addr", 32'(mc_addr), 32'h020000);
      step(5);
      chk("t4_ldr_ack", 32'(ldr_ack), 32'd1);
      step(1);
      chk("t4_ppu_next", 32'(mc_read_b), 32'd1);
      step(5);
      chk("t4_ppu_ack", 32'(ppu_ack), 32'd1);
      step(1);
      chk("t4_cpu_next", 32'(mc_read_a), 32'd1);
      step(5);
      chk("t4_cpu_ack", 32'(cpu_ack), 32'd1);
      step(2);

      // second CPU request while pending
      a0 = cpu_acks;
      cpu_req = 1'b1; cpu_addr = 22'h380010;
      step(1);
      chk("t5_overrun_clear", 32'(overrun), 32'd0);
      cpu_addr = 22'h380044;
      step(1); cpu_req = 1'b0;
      chk("t5_overrun_set", 32'(overrun), 32'd1);
      chk("t5_read_a", 32'(mc_read_a), 32'd1);
      chk("t5_orig_addr", 32'(mc_addr), 32'h380010);
      step(5);
      chk("t5_cpu_ack", 32'(cpu_ack), 32'd1);
      chk("t5_cpu_dout", 32'(cpu_dout), 32'h5A);
      step(8);
      chk("t5_single_ack", 32'(cpu_acks - a0), 32'd1);
      chk("t5_overrun_sticky", 32'(overrun), 32'd1);

      // reset while waiting for busy to rise
      a0 = cpu_acks;
      cpu_req = 1'b1; cpu_addr = 22'h380010;
      step(1); cpu_req = 1'b0;
      step(1);
      chk("t6_read_a", 32'(mc_read_a), 32'd1);
      step(1);
      chk("t6_busy_up", 32'(mc_busy), 32'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("t6_no_ack", 32'(cpu_ack), 32'd0);
      chk("t6_overrun_reset", 32'(overrun), 32'd0);
      chk("t6_strobes_off", {29'd0, mc_read_a, mc_read_b, mc_write}, 32'd0);
      chk("t6_mc_addr_reset", 32'(mc_addr), 32'd0);
      cpu_req = 1'b1; cpu_addr = 22'h380020;
      step(1); cpu_req = 1'b0;
      chk("t6_hold_busy", {30'd0, mc_busy, mc_read_a}, 32'd2);
      step(1);
      chk("t6_busy_fell", {30'd0, mc_busy, mc_read_a}, 32'd0);
      step(1);
      chk("t6_strobe_after_busy", 32'(mc_read_a), 32'd1);
      chk("t6_new_addr", 32'(mc_addr), 32'h380020);
      step(5);
      chk("t6_aborted_no_ack", 32'(cpu_acks - a0), 32'd0);
      chk("t6_new_ack", 32'(cpu_ack), 32'd1);
      chk("t6_new_dout", 32'(cpu_dout), 32'h1C);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
